axil_to_avmm_bridge: RTL and testbench

AXIL_TO_AVMM_BRIDGE -- requirements
Module: axil_to_avmm_bridge

---
 rtl/axe5_bridge_pkg.sv | 21 ++
 rtl/avmm_timeout_cnt.sv | 43 ++++
 rtl/axil_to_avmm_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_axil_to_avmm_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axe5_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to Avalon-MM bridge.
//   bridge_state_e : bridge FSM states
//   AxiRespOkay / AxiRespSlvErr : AXI response codes returned on B and R
//   CntW : width of the Avalon timeout counter
package axe5_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrCmd,
    StRdCmd,
    StRdWait,
    StWrRsp,
    StRdRsp
  } bridge_state_e;

  localparam logic [1:0] AxiRespOkay   = 2'b00;
  localparam logic [1:0] AxiRespSlvErr = 2'b10;

  localparam int unsigned CntW = 16;

endpackage

// File: rtl/avmm_timeout_cnt.sv
// Avalon request/response timeout counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : clear the count (pulsed while launching a new Avalon command)
//   run        : count one cycle (high while a command or read response is pending)
//   expired    : count has reached TIMEOUT_CYCLES-1 while running
module avmm_timeout_cnt
  import axe5_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && (cnt_q != '1)) begin
      // Saturate so a late expiry can never wrap back into a long wait.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= so that a read accepted on the expiry cycle still times out in RD_WAIT.
  assign expired = run && (cnt_q >= Limit);

endmodule

// File: rtl/axil_to_avmm_bridge.sv
// AXI4-Lite slave to Avalon-MM master bridge, one Avalon transaction at a time.
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset (2-flop synchronised release)
//   s_axi_aw* / s_axi_w*   : write address / data, each captured into a one-entry holder
//   s_axi_b*               : write response (OKAY, or SLVERR on Avalon timeout)
//   s_axi_ar* / s_axi_r*   : read address holder and read data/response
//   avm_*                  : Avalon-MM master command and response
module axil_to_avmm_bridge
  import axe5_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  // AXI4-Lite slave
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  // Avalon-MM master
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_burstcount,
  output logic                avm_debugaccess,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int unsigned StrbW = DATA_W / 8;

  // Reset: assert asynchronously, release after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Holders and channel handshakes
  logic              aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [StrbW-1:0]  w_strb_q;
  logic              aw_hs, w_hs, ar_hs;
  logic              wr_avail, rd_avail;

  // A holder stays full while its transaction is serviced, so ready is simply "empty".
  assign s_axi_awready = rst_n & ~aw_full_q;
  assign s_axi_wready  = rst_n & ~w_full_q;
  assign s_axi_arready = rst_n & ~ar_full_q;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  // Count a beat being captured this cycle so the command issues on the very next cycle.
  assign wr_avail = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign rd_avail = ar_full_q | ar_hs;

  // FSM and response registers
  bridge_state_e     state_q, state_d;
  logic              wr_first_q, wr_first_d;
  logic              cnt_start, cnt_run, expired;
  logic              clr_wr, clr_rd;
  logic              b_load, r_load;
  logic [1:0]        b_resp_nxt, r_resp_nxt;
  logic [DATA_W-1:0] r_data_nxt;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end else if (clr_wr) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end else if (clr_wr) begin
        w_full_q <= 1'b0;
      end
      if (ar_hs) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_axi_araddr;
      end else if (clr_rd) begin
        ar_full_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_first_d = wr_first_q;
    cnt_start  = 1'b0;
    clr_wr     = 1'b0;
    clr_rd     = 1'b0;
    b_load     = 1'b0;
    b_resp_nxt = AxiRespOkay;
    r_load     = 1'b0;
    r_resp_nxt = AxiRespOkay;
    r_data_nxt = '0;
    unique case (state_q)
      StIdle: begin
        if (wr_avail && rd_avail) begin
          // Only a genuine conflict moves the grant pointer.
          state_d    = wr_first_q ? StWrCmd : StRdCmd;
          wr_first_d = ~wr_first_q;
          cnt_start  = 1'b1;
        end else if (wr_avail) begin
          state_d   = StWrCmd;
          cnt_start = 1'b1;
        end else if (rd_avail) begin
          state_d   = StRdCmd;
          cnt_start = 1'b1;
        end
      end
      StWrCmd: begin
        if (!avm_waitrequest) begin
          state_d = StWrRsp;
          b_load  = 1'b1;
        end else if (expired) begin
          state_d    = StWrRsp;
          b_load     = 1'b1;
          b_resp_nxt = AxiRespSlvErr;
        end
      end
      StRdCmd: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            state_d    = StRdRsp;
            r_load     = 1'b1;
            r_data_nxt = avm_readdata;
          end else begin
            state_d = StRdWait;
          end
        end else if (expired) begin
          state_d    = StRdRsp;
          r_load     = 1'b1;
          r_resp_nxt = AxiRespSlvErr;
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          state_d    = StRdRsp;
          r_load     = 1'b1;
          r_data_nxt = avm_readdata;
        end else if (expired) begin
          state_d    = StRdRsp;
          r_load     = 1'b1;
          r_resp_nxt = AxiRespSlvErr;
        end
      end
      StWrRsp: begin
        if (s_axi_bready) begin
          state_d = StIdle;
          clr_wr  = 1'b1;
        end
      end
      StRdRsp: begin
        if (s_axi_rready) begin
          state_d = StIdle;
          clr_rd  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_first_q <= 1'b1;
      bresp_q    <= AxiRespOkay;
      rresp_q    <= AxiRespOkay;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_first_q <= wr_first_d;
      if (b_load) begin
        bresp_q <= b_resp_nxt;
      end
      if (r_load) begin
        rresp_q <= r_resp_nxt;
        rdata_q <= r_data_nxt;
      end
    end
  end

  assign cnt_run = (state_q == StWrCmd) || (state_q == StRdCmd) || (state_q == StRdWait);

  avmm_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk_clk),
    .rst_n  (rst_n),
    .start  (cnt_start),
    .run    (cnt_run),
    .expired(expired)
  );

  // Outputs
  assign avm_write       = (state_q == StWrCmd);
  assign avm_read        = (state_q == StRdCmd);
  assign avm_address     = (state_q == StWrCmd) ? aw_addr_q : ar_addr_q;
  assign avm_writedata   = w_data_q;
  assign avm_byteenable  = (state_q == StWrCmd) ? w_strb_q : {StrbW{1'b1}};
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;

  assign s_axi_bvalid = (state_q == StWrRsp);
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = (state_q == StRdRsp);
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;

endmodule

// File: tb/tb_axil_to_avmm_bridge.sv
module tb_axil_to_avmm_bridge;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [AW-1:0] s_axi_awaddr;
  logic          s_axi_awvalid, s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [3:0]    s_axi_wstrb;
  logic          s_axi_wvalid, s_axi_wready;
  logic [1:0]    s_axi_bresp;
  logic          s_axi_bvalid, s_axi_bready;
  logic [AW-1:0] s_axi_araddr;
  logic          s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rvalid, s_axi_rready;
  logic [AW-1:0] avm_address;
  logic          avm_read, avm_write;
  logic [DW-1:0] avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_burstcount, avm_debugaccess;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;

  axil_to_avmm_bridge #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .s_axi_awaddr     (s_axi_awaddr),
    .s_axi_awvalid    (s_axi_awvalid),
    .s_axi_awready    (s_axi_awready),
    .s_axi_wdata      (s_axi_wdata),
    .s_axi_wstrb      (s_axi_wstrb),
    .s_axi_wvalid     (s_axi_wvalid),
    .s_axi_wready     (s_axi_wready),
    .s_axi_bresp      (s_axi_bresp),
    .s_axi_bvalid     (s_axi_bvalid),
    .s_axi_bready     (s_axi_bready),
    .s_axi_araddr     (s_axi_araddr),
    .s_axi_arvalid    (s_axi_arvalid),
    .s_axi_arready    (s_axi_arready),
    .s_axi_rdata      (s_axi_rdata),
    .s_axi_rresp      (s_axi_rresp),
    .s_axi_rvalid     (s_axi_rvalid),
    .s_axi_rready     (s_axi_rready),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_burstcount   (avm_burstcount),
    .avm_debugaccess  (avm_debugaccess),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int errors = 0;

  // Avalon peripheral model knobs
  int   wait_cycles = 0;
  int   rdv_delay   = 1;
  bit   rdv_enable  = 1'b1;
  bit   inject_rdv  = 1'b0;
  int   cmd_age     = 0;
  int   rdv_cnt     = 0;
  int   stable_err  = 0;
  bit   cmd_seen    = 1'b0;
  logic [AW-1:0] cur_addr;
  logic [31:0]   rdv_data;
  logic [31:0]   mem     [16];
  logic [31:0]   ref_mem [16];

  // Accepted Avalon commands, in order
  bit          log_wr   [$];
  logic [AW-1:0] log_addr [$];
  logic [31:0] log_data [$];
  logic [3:0]  log_be   [$];

  always @(negedge clk_clk) begin
    avm_waitrequest   = 1'b1;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'hDEAD_BEEF;
    if (inject_rdv) begin
      inject_rdv        = 1'b0;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hBAD0_BAD0;
    end
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rdv_data;
      end
    end
    if (avm_read || avm_write) begin
      if (cmd_seen && (avm_address !== cur_addr)) stable_err++;
      cmd_seen = 1'b1;
      cur_addr = avm_address;
      if (cmd_age < wait_cycles) begin
        cmd_age++;
      end else begin
        avm_waitrequest = 1'b0;
        cmd_age  = 0;
        cmd_seen = 1'b0;
        log_wr.push_back(avm_write);
        log_addr.push_back(avm_address);
        log_data.push_back(avm_writedata);
        log_be.push_back(avm_byteenable);
        if (avm_write) begin
          for (int b = 0; b < 4; b++)
            if (avm_byteenable[b]) mem[avm_address[5:2]][8*b +: 8] = avm_writedata[8*b +: 8];
        end else if (rdv_enable) begin
          rdv_data = mem[avm_address[5:2]];
          if (rdv_delay == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rdv_data;
          end else begin
            rdv_cnt = rdv_delay;
          end
        end
      end
    end else begin
      cmd_age  = 0;
      cmd_seen = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic check_log(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    int n;
    n = log_wr.size();
    chk({tag, "_present"}, 32'(n != 0), 32'd1);
    if (n != 0) begin
      chk({tag, "_wr"}, 32'(log_wr.pop_front()), 32'(wr));
      chk({tag, "_addr"}, 32'(log_addr.pop_front()), 32'(addr));
      if (wr) begin
        chk({tag, "_data"}, log_data.pop_front(), data);
        chk({tag, "_be"}, 32'(log_be.pop_front()), 32'(be));
      end else begin
        void'(log_data.pop_front());
        void'(log_be.pop_front());
      end
    end
  endtask

  // Drive the requested AXI address/data channels together; return on the negedge
  // following the last handshake edge.
  task automatic present(input bit do_aw, input bit do_w, input bit do_ar,
                         input logic [AW-1:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [AW-1:0] raddr);
    bit aw_p, w_p, ar_p, aw_h, w_h, ar_h;
    int n;
    aw_p = do_aw; w_p = do_w; ar_p = do_ar;
    s_axi_awaddr = waddr; s_axi_wdata = wdata; s_axi_wstrb = wstrb; s_axi_araddr = raddr;
    s_axi_awvalid = do_aw; s_axi_wvalid = do_w; s_axi_arvalid = do_ar;
    n = 0;
    while ((aw_p || w_p || ar_p) && n < 50) begin
      aw_h = aw_p && s_axi_awready;
      w_h  = w_p && s_axi_wready;
      ar_h = ar_p && s_axi_arready;
      @(negedge clk_clk);
      n++;
      if (aw_h) begin aw_p = 1'b0; s_axi_awvalid = 1'b0; end
      if (w_h)  begin w_p = 1'b0;  s_axi_wvalid = 1'b0;  end
      if (ar_h) begin ar_p = 1'b0; s_axi_arvalid = 1'b0; end
    end
    chk("addr_handshake_pending", 32'({aw_p, w_p, ar_p}), 32'd0);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
  endtask

  task automatic collect(input bit want_b, input bit want_r, output logic [1:0] bresp,
                         output logic [1:0] rresp, output logic [31:0] rdata);
    bit b_p, r_p, b_got, r_got;
    int n;
    bresp = 'x; rresp = 'x; rdata = 'x;
    b_p = want_b; r_p = want_r; b_got = 1'b0; r_got = 1'b0;
    s_axi_bready = want_b; s_axi_rready = want_r;
    n = 0;
    while ((b_p || r_p) && n < 100) begin
      if (b_p && s_axi_bvalid) begin bresp = s_axi_bresp; b_got = 1'b1; end
      if (r_p && s_axi_rvalid) begin rresp = s_axi_rresp; rdata = s_axi_rdata; r_got = 1'b1; end
      @(negedge clk_clk);
      n++;
      if (b_got) begin b_p = 1'b0; s_axi_bready = 1'b0; b_got = 1'b0; end
      if (r_got) begin r_p = 1'b0; s_axi_rready = 1'b0; r_got = 1'b0; end
    end
    chk("response_pending", 32'({b_p, r_p}), 32'd0);
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
    chk({tag, "_arready_sync1"}, 32'(s_axi_arready), 32'd0);
    @(negedge clk_clk);
    chk({tag, "_arready_sync2"}, 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    br, rr;
    logic [31:0]   rd, d;
    logic [AW-1:0] a;
    logic [3:0]    s;
    int            n;
    bit            wr;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8] = 32'h0000_0003;
    ref_mem[8] = 32'h0000_0003;

    reset_reset_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(negedge clk_clk);

    // Reset state
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_avm_read", 32'(avm_read), 32'd0);
    chk("rst_avm_write", 32'(avm_write), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("burstcount", 32'(avm_burstcount), 32'd1);
    chk("debugaccess", 32'(avm_debugaccess), 32'd0);
    release_reset("init");

    // Single write, zero waitrequest: command in N+1, bvalid in N+2
    wait_cycles = 0;
    present(1, 1, 0, 24'h00_0010, 32'hA5A5_1234, 4'hF, '0);
    chk("wr_cmd_n1", 32'(avm_write), 32'd1);
    chk("wr_cmd_addr", 32'(avm_address), 32'h10);
    chk("wr_cmd_data", avm_writedata, 32'hA5A5_1234);
    @(negedge clk_clk);
    chk("wr_cmd_one_cycle", 32'(avm_write), 32'd0);
    chk("wr_bvalid_n2", 32'(s_axi_bvalid), 32'd1);
    collect(1, 0, br, rr, rd);
    chk("wr_bresp", 32'(br), 32'd0);
    ref_write(24'h10, 32'hA5A5_1234, 4'hF);
    check_log("wr1", 1, 24'h10, 32'hA5A5_1234, 4'hF);

    // Read with 3 waitrequest cycles and delayed readdatavalid
    wait_cycles = 3; rdv_delay = 2; rdv_enable = 1'b1;
    present(0, 0, 1, '0, '0, '0, 24'h00_0020);
    collect(0, 1, br, rr, rd);
    chk("rd_rdata", rd, 32'h0000_0003);
    chk("rd_rresp", 32'(rr), 32'd0);
    chk("rd_addr_stable", 32'(stable_err), 32'd0);
    check_log("rd1", 0, 24'h20, '0, '0);

    // Two simultaneous write+read pairs: write, read, then read, write
    wait_cycles = 1; rdv_delay = 1;
    present(1, 1, 1, 24'h04, 32'h1357_9BDF, 4'hF, 24'h08);
    collect(1, 1, br, rr, rd);
    chk("pair1_bresp", 32'(br), 32'd0);
    chk("pair1_rresp", 32'(rr), 32'd0);
    chk("pair1_rdata", rd, ref_mem[2]);
    ref_write(24'h04, 32'h1357_9BDF, 4'hF);
    check_log("pair1_first", 1, 24'h04, 32'h1357_9BDF, 4'hF);
    check_log("pair1_second", 0, 24'h08, '0, '0);
    present(1, 1, 1, 24'h0C, 32'hCAFE_F00D, 4'h3, 24'h14);
    collect(1, 1, br, rr, rd);
    chk("pair2_bresp", 32'(br), 32'd0);
    chk("pair2_rdata", rd, ref_mem[5]);
    ref_write(24'h0C, 32'hCAFE_F00D, 4'h3);
    check_log("pair2_first", 0, 24'h14, '0, '0);
    check_log("pair2_second", 1, 24'h0C, 32'hCAFE_F00D, 4'h3);

    // W arrives 5 cycles before AW
    wait_cycles = 0;
    present(0, 1, 0, '0, 32'h1111_2222, 4'b0101, '0);
    for (int i = 0; i < 5; i++) begin
      chk("w_early_wready", 32'(s_axi_wready), 32'd0);
      chk("w_early_no_write", 32'(avm_write), 32'd0);
      @(negedge clk_clk);
    end
    present(1, 0, 0, 24'h18, 32'h1111_2222, 4'b0101, '0);
    chk("w_late_aw_write", 32'(avm_write), 32'd1);
    chk("w_late_aw_data", avm_writedata, 32'h1111_2222);
    collect(1, 0, br, rr, rd);
    ref_write(24'h18, 32'h1111_2222, 4'b0101);
    check_log("w_early", 1, 24'h18, 32'h1111_2222, 4'b0101);
    chk("w_early_single", 32'(log_wr.size()), 32'd0);

    // Read timeout: readdatavalid never comes
    wait_cycles = 0; rdv_enable = 1'b0;
    present(0, 0, 1, '0, '0, '0, 24'h24);
    n = 0;
    while (!s_axi_rvalid && n < 100) begin
      @(negedge clk_clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_avm_read", 32'(avm_read), 32'd0);
    inject_rdv = 1'b1;
    repeat (3) @(negedge clk_clk);
    chk("to_late_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("to_late_rdata", s_axi_rdata, 32'd0);
    collect(0, 1, br, rr, rd);
    chk("to_rresp", 32'(rr), 32'd2);
    chk("to_rdata", rd, 32'd0);
    check_log("to_rd", 0, 24'h24, '0, '0);
    inject_rdv = 1'b1;
    repeat (2) @(negedge clk_clk);
    chk("to_idle_rvalid", 32'(s_axi_rvalid), 32'd0);
    rdv_enable = 1'b1; rdv_delay = 1;
    present(0, 0, 1, '0, '0, '0, 24'h24);
    collect(0, 1, br, rr, rd);
    chk("after_to_rdata", rd, ref_mem[9]);
    chk("after_to_rresp", 32'(rr), 32'd0);
    check_log("after_to", 0, 24'h24, '0, '0);

    // Reset during RD_WAIT with rready low
    rdv_enable = 1'b0;
    present(0, 0, 1, '0, '0, '0, 24'h28);
    @(negedge clk_clk);
    chk("rw_pre_rvalid", 32'(s_axi_rvalid), 32'd0);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("rw_rst_avm_read", 32'(avm_read), 32'd0);
    chk("rw_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rw_rst_arready", 32'(s_axi_arready), 32'd0);
    release_reset("rw");
    log_wr.delete(); log_addr.delete(); log_data.delete(); log_be.delete();

    // Reset while the read command is still being held off
    wait_cycles = 1000;
    present(0, 0, 1, '0, '0, '0, 24'h2C);
    chk("rc_pre_avm_read", 32'(avm_read), 32'd1);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("rc_rst_avm_read", 32'(avm_read), 32'd0);
    release_reset("rc");
    chk("rc_no_accept", 32'(log_wr.size()), 32'd0);

    // Next read completes normally
    wait_cycles = 0; rdv_enable = 1'b1; rdv_delay = 1;
    present(0, 0, 1, '0, '0, '0, 24'h20);
    collect(0, 1, br, rr, rd);
    chk("post_rst_rdata", rd, ref_mem[8]);
    chk("post_rst_rresp", 32'(rr), 32'd0);
    check_log("post_rst", 0, 24'h20, '0, '0);

    // Random transactions against the memory model
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = AW'({$urandom_range(0, 15), 2'b00});
      wait_cycles = $urandom_range(0, 3);
      rdv_delay = $urandom_range(0, 3);
      if (wr) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        present(1, 1, 0, a, d, s, '0);
        collect(1, 0, br, rr, rd);
        chk("rand_bresp", 32'(br), 32'd0);
        ref_write(a, d, s);
        check_log("rand_wr", 1, a, d, s);
      end else begin
        present(0, 0, 1, '0, '0, '0, a);
        collect(0, 1, br, rr, rd);
        chk("rand_rresp", 32'(rr), 32'd0);
        chk("rand_rdata", rd, ref_mem[a[5:2]]);
        check_log("rand_rd", 0, a, '0, '0);
      end
    end
    chk("rand_addr_stable", 32'(stable_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
